bios_wdt_timer: RTL and testbench
=================================

Name: bios_wdt_timer

Overview:
Receiving end of the BIOS watchdog write path, in the CLK32768 domain. Consumes the 5-bit toggle vector bCPUWrWdtRegSig, which carries one toggle bit per decoded BIOS write code, and turns each toggle into a one-cycle command. Commands drive a seconds-based watchdog FSM. On timeout the block pulses a platform reset and swaps the active BIOS image select.

Parameters:
TIMEOUT_SEC, 180, reload value in seconds; legal range 1..255.
TICK_DIV, 32768, CLK32768 cycles per second tick; reduced in simulation.
RST_PULSE_CYC, 4, width of the WdtRstN low pulse in cycles; range 1..15.
DEFAULT_ARMED, 1, 1 = watchdog is armed when reset is released.

Ports:
CLK32768  in  1  32.768 kHz clock; the only clock in the block.
MainResetN  in  1  reset; synchronous, active-low.
bCPUWrWdtRegSig  in  5  toggle vector. bit0 = 0x55 kick, bit1 = 0x29 disable, bit2 = 0xFF force, bit3 = 0xAA arm, bit4 = any other code.
WdtRstN  out  1  platform reset request, active-low pulse.
BiosSel  out  1  active BIOS image select; inverts on each expiry.
WdtArmed  out  1  1 while the FSM is in ARMED.
WdtRemainSec  out  8  remaining seconds.
WdtExpCnt  out  2  expiry count; saturates at 3.

Behaviour:
- Clock and reset: one clock, CLK32768. Reset is synchronous and active-low on MainResetN. All registers take reset values on a clock edge while MainResetN=0.
- Reset values:
  - WdtRstN=1, BiosSel=0, WdtExpCnt=0, WdtRemainSec=TIMEOUT_SEC, prescaler=0.
  - WdtArmed=DEFAULT_ARMED; FSM state = ARMED if DEFAULT_ARMED else IDLE.
- Toggle detection:
  - Input passes through one sync stage (sync_q), then a previous-value register (prev_q).
  - evt[i] = sync_q[i] ^ prev_q[i].
  - A primed flag clears on reset. On the first cycle after reset, prev_q loads sync_q and no events are raised. This prevents a spurious event after reset mid-operation.
- Latency: a toggle sampled at edge k produces evt at edge k+1. State and outputs update at edge k+2.
- Simultaneous events, one command per cycle, priority: disable > kick > arm > force > other. Lower-priority events in the same cycle are dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in ARMED. tick = (prescaler == TICK_DIV-1). Wraps to 0.
  - Held at 0 in IDLE and EXPIRE.
- FSM states: IDLE, ARMED, EXPIRE.
- IDLE:
  - arm → ARMED, load WdtRemainSec=TIMEOUT_SEC, prescaler=0.
  - kick, force, disable and other are ignored.
- ARMED:
  - disable → IDLE; WdtRemainSec holds its value.
  - kick → reload WdtRemainSec and prescaler; stays in ARMED.
  - arm → same as kick.
  - force → EXPIRE.
  - tick with WdtRemainSec>1 → decrement.
  - tick with WdtRemainSec==1 → EXPIRE, WdtRemainSec=0. Expiry therefore occurs exactly TIMEOUT_SEC*TICK_DIV cycles after a load.
  - A command in the same cycle as tick overrides the tick.
- EXPIRE:
  - On entry: WdtRstN=0, BiosSel inverts, WdtExpCnt increments (saturates at 3), pulse counter=0.
  - Stays RST_PULSE_CYC cycles. All commands are ignored.
  - Then WdtRstN=1 → ARMED with reload. A new boot attempt is always watched.
- WdtArmed = (state == ARMED), registered.
- Reset asserted during EXPIRE: the pulse ends immediately (WdtRstN=1). BiosSel returns to 0.

Optional Feature:
BIOS_WDT_STRICT_EN
- Defined: the other event (bit4, an invalid code) in ARMED → EXPIRE, like force. It keeps its lowest priority.
- Undefined: the other event is ignored in all states.

Decomposition:
- Package bios_wdt_pkg:
  - state enum {IDLE, ARMED, EXPIRE}.
  - Event bit indices: EVT_KICK=0, EVT_DIS=1, EVT_FORCE=2, EVT_ARM=3, EVT_OTHER=4.
  - Code constants 0x55, 0x29, 0xFF, 0xAA, for documentation and the decoder.
- Sub-module bios_wdt_toggle_det: sync stage, prev register, primed flag and evt vector, parameterised on width 5.
- Top: priority encoder, prescaler, seconds counter, FSM, pulse counter.

Test Plan:
Bench settings TICK_DIV=4, TIMEOUT_SEC=3, RST_PULSE_CYC=2 unless stated.
1. Release reset, no toggles → WdtRemainSec 3→2→1 at cycles 4 and 8; WdtRstN low on cycles 12–13; BiosSel 0→1; WdtExpCnt=1; back in ARMED with WdtRemainSec=3.
2. Toggle bit0 at edge 6 → WdtRemainSec=3 at edge 8, prescaler=0; expiry at edge 20.
3. Toggle bit1 → WdtArmed=0 two cycles later, no WdtRstN low for 200 cycles. Then toggle bit3 → WdtArmed=1, WdtRemainSec=3, expiry 12 cycles after the load.
4. Toggle bit0 and bit1 in the same cycle → disable wins, IDLE. Toggle bit2 while in IDLE → no effect.
5. Toggle bit2 while ARMED → WdtRstN=0 two edges later for 2 cycles. Repeat four expiries → WdtExpCnt sticks at 3; BiosSel alternates.
6. Toggle bit4 while ARMED → expiry with BIOS_WDT_STRICT_EN defined, no change without it. Pulse MainResetN low with input held at 5'b10101 → no event after release.

Source files
------------

// File: rtl/bios_wdt_pkg.sv
// Shared types and constants for the BIOS watchdog receive path.
// The optional build macro BIOS_WDT_STRICT_EN is handled in bios_wdt_timer.
package bios_wdt_pkg;

  localparam int NUM_EVT   = 5;

  // Bit positions inside the toggle vector.
  localparam int EVT_KICK  = 0;
  localparam int EVT_DIS   = 1;
  localparam int EVT_FORCE = 2;
  localparam int EVT_ARM   = 3;
  localparam int EVT_OTHER = 4;

  // BIOS write codes that the CPU-side decoder maps onto the bits above.
  localparam logic [7:0] CODE_KICK  = 8'h55;
  localparam logic [7:0] CODE_DIS   = 8'h29;
  localparam logic [7:0] CODE_FORCE = 8'hFF;
  localparam logic [7:0] CODE_ARM   = 8'hAA;

  typedef enum logic [1:0] {IDLE, ARMED, EXPIRE} wdt_state_e;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_DIS, CMD_KICK, CMD_ARM, CMD_FORCE, CMD_OTHER
  } wdt_cmd_e;

  // One command per cycle: disable > kick > arm > force > other.
  function automatic wdt_cmd_e decodeCmd(input logic [NUM_EVT-1:0] evt);
    wdt_cmd_e cmd;
    cmd = CMD_NONE;
    if (evt[EVT_DIS])        cmd = CMD_DIS;
    else if (evt[EVT_KICK])  cmd = CMD_KICK;
    else if (evt[EVT_ARM])   cmd = CMD_ARM;
    else if (evt[EVT_FORCE]) cmd = CMD_FORCE;
    else if (evt[EVT_OTHER]) cmd = CMD_OTHER;
    return cmd;
  endfunction

endpackage

// File: rtl/bios_wdt_timer_if.sv
// Toggle-vector input and watchdog status outputs of the BIOS watchdog.
interface bios_wdt_timer_if;
  import bios_wdt_pkg::*;

  logic [NUM_EVT-1:0] bCPUWrWdtRegSig;
  logic               WdtRstN;
  logic               BiosSel;
  logic               WdtArmed;
  logic [7:0]         WdtRemainSec;
  logic [1:0]         WdtExpCnt;

  modport master (output bCPUWrWdtRegSig,
                  input  WdtRstN, BiosSel, WdtArmed, WdtRemainSec, WdtExpCnt);
  modport slave  (input  bCPUWrWdtRegSig,
                  output WdtRstN, BiosSel, WdtArmed, WdtRemainSec, WdtExpCnt);
endinterface

// File: rtl/bios_wdt_toggle_det.sv
// Turns each toggle of an asynchronous level vector into a one-cycle event.
// The sync stage keeps sampling through reset so that, once reset drops,
// the first cycle only primes prev with the settled input and no stale
// difference is reported.
module bios_wdt_toggle_det #(
  parameter int W = 5
) (
  input  logic         CLK32768,
  input  logic         MainResetN,
  input  logic [W-1:0] sigIn,
  output logic [W-1:0] evt
);

  logic [W-1:0] syncQ;
  logic [W-1:0] prevQ;
  logic         primed;

  // Single sync stage, free-running so it holds the live input at release.
  always_ff @(posedge CLK32768) begin
    syncQ <= sigIn;
  end

  // Edge detect; events are suppressed on the first cycle after reset.
  always_ff @(posedge CLK32768) begin
    if (!MainResetN) begin
      prevQ  <= '0;
      primed <= 1'b0;
      evt    <= '0;
    end else begin
      prevQ  <= syncQ;
      primed <= 1'b1;
      evt    <= primed ? (syncQ ^ prevQ) : '0;
    end
  end

endmodule

// File: rtl/bios_wdt_timer.sv
// Seconds-based BIOS watchdog: toggle commands, prescaler, countdown,
// reset pulse on expiry and BIOS image swap.
// Build option: define BIOS_WDT_STRICT_EN to make an invalid-code write
// while armed expire the watchdog just like a force.
module bios_wdt_timer
  import bios_wdt_pkg::*;
#(
  parameter int TIMEOUT_SEC   = 180,
  parameter int TICK_DIV      = 32768,
  parameter int RST_PULSE_CYC = 4,
  parameter int DEFAULT_ARMED = 1
) (
  input  logic             CLK32768,
  input  logic             MainResetN,
  bios_wdt_timer_if.slave  wdtIf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0]    RELOAD   = 8'(TIMEOUT_SEC);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    PLS_LAST = 4'(RST_PULSE_CYC - 1);
  localparam wdt_state_e    ST_RST   = (DEFAULT_ARMED != 0) ? ARMED : IDLE;

  logic [NUM_EVT-1:0] evt;
  wdt_cmd_e           cmd;
  logic               tick;
  logic               otherExpires;
  logic               enterExp;

  wdt_state_e    stateQ, stateD;
  logic [PW-1:0] preQ,   preD;
  logic [7:0]    remQ,   remD;
  logic [3:0]    pcntQ,  pcntD;
  logic          rstNQ,  rstND;
  logic          biosQ,  biosD;
  logic [1:0]    cntQ,   cntD;
  logic          armedQ;

  bios_wdt_toggle_det #(.W(NUM_EVT)) uTglDet (
    .CLK32768   (CLK32768),
    .MainResetN (MainResetN),
    .sigIn      (wdtIf.bCPUWrWdtRegSig),
    .evt        (evt)
  );

  assign cmd  = decodeCmd(evt);
  assign tick = (preQ == PRE_LAST);

`ifdef BIOS_WDT_STRICT_EN
  assign otherExpires = (cmd == CMD_OTHER);
`else
  assign otherExpires = 1'b0;
`endif

  // Next-state logic; a command in a tick cycle takes precedence over it.
  always_comb begin
    stateD   = stateQ;
    preD     = '0;
    remD     = remQ;
    pcntD    = pcntQ;
    rstND    = rstNQ;
    biosD    = biosQ;
    cntD     = cntQ;
    enterExp = 1'b0;
    case (stateQ)
      IDLE: begin
        if (cmd == CMD_ARM) begin
          stateD = ARMED;
          remD   = RELOAD;
        end
      end
      ARMED: begin
        preD = tick ? '0 : preQ + PW'(1);
        if (cmd == CMD_DIS) begin
          stateD = IDLE;
          preD   = '0;
        end else if (cmd == CMD_KICK || cmd == CMD_ARM) begin
          remD = RELOAD;
          preD = '0;
        end else if (cmd == CMD_FORCE || otherExpires) begin
          enterExp = 1'b1;
        end else if (tick) begin
          if (remQ > 8'd1) begin
            remD = remQ - 8'd1;
          end else begin
            remD     = '0;
            enterExp = 1'b1;
          end
        end
      end
      EXPIRE: begin
        if (pcntQ == PLS_LAST) begin
          stateD = ARMED;
          rstND  = 1'b1;
          remD   = RELOAD;
        end else begin
          pcntD = pcntQ + 4'd1;
        end
      end
      default: stateD = ST_RST;
    endcase
    if (enterExp) begin
      stateD = EXPIRE;
      preD   = '0;
      pcntD  = '0;
      rstND  = 1'b0;
      biosD  = ~biosQ;
      cntD   = (cntQ == 2'd3) ? 2'd3 : cntQ + 2'd1;
    end
  end

  // State registers; reset also ends an in-flight reset pulse.
  always_ff @(posedge CLK32768) begin
    if (!MainResetN) begin
      stateQ <= ST_RST;
      preQ   <= '0;
      remQ   <= RELOAD;
      pcntQ  <= '0;
      rstNQ  <= 1'b1;
      biosQ  <= 1'b0;
      cntQ   <= '0;
      armedQ <= (DEFAULT_ARMED != 0);
    end else begin
      stateQ <= stateD;
      preQ   <= preD;
      remQ   <= remD;
      pcntQ  <= pcntD;
      rstNQ  <= rstND;
      biosQ  <= biosD;
      cntQ   <= cntD;
      armedQ <= (stateD == ARMED);
    end
  end

  assign wdtIf.WdtRstN      = rstNQ;
  assign wdtIf.BiosSel      = biosQ;
  assign wdtIf.WdtArmed     = armedQ;
  assign wdtIf.WdtRemainSec = remQ;
  assign wdtIf.WdtExpCnt    = cntQ;

endmodule

// File: tb/tb_bios_wdt_timer.sv
// Bench for bios_wdt_timer: reference table, directed corner sequences and
// random toggles checked every cycle against a timeline model.
module tb_bios_wdt_timer;

  localparam int TO = 3;
  localparam int TD = 4;
  localparam int RP = 2;
`ifdef BIOS_WDT_STRICT_EN
  localparam int STRICT = 1;
`else
  localparam int STRICT = 0;
`endif

  logic CLK32768   = 1'b0;
  logic MainResetN = 1'b0;

  bios_wdt_timer_if tbIf();

  bios_wdt_timer #(
    .TIMEOUT_SEC(TO), .TICK_DIV(TD), .RST_PULSE_CYC(RP), .DEFAULT_ARMED(1)
  ) dut (
    .CLK32768   (CLK32768),
    .MainResetN (MainResetN),
    .wdtIf      (tbIf)
  );

  always #5 CLK32768 = ~CLK32768;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  logic [4:0] sig = 5'b0;

  // Model: mode 0 idle, 1 armed, 2 expire. Countdown derived from load time.
  int mMode, loadCyc, expStart, mRem, mBios, mCnt;
  logic       h1r = 1'b0, h2r = 1'b0;
  logic [4:0] h1s = '0, h2s = '0, h3s = '0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", nm, n, got, exp);
    end
  endtask

  task automatic enterExp();
    mMode    = 2;
    expStart = n;
    mBios    = mBios ^ 1;
    if (mCnt < 3) mCnt++;
  endtask

  task automatic modelStep(input logic rst, input logic [4:0] s);
    logic [4:0] e;
    int d;
    // An input change seen at edge n-2 acts at edge n, if not masked by reset.
    e   = (h1r && h2r) ? (h2s ^ h3s) : 5'b0;
    h3s = h2s; h2s = h1s; h1s = s;
    h2r = h1r; h1r = rst;
    if (!rst) begin
      mMode = 1; loadCyc = n; mRem = TO; mBios = 0; mCnt = 0;
    end else begin
      case (mMode)
        0: if (!e[1] && !e[0] && e[3]) begin
             mMode = 1; loadCyc = n; mRem = TO;
           end
        1: begin
          if (e[1]) mMode = 0;
          else if (e[0] || e[3]) begin loadCyc = n; mRem = TO; end
          else if (e[2] || (STRICT != 0 && e[4])) enterExp();
          else begin
            d = n - loadCyc;
            if (d == TO * TD) begin mRem = 0; enterExp(); end
            else mRem = TO - d / TD;
          end
        end
        default: if (n - expStart == RP) begin
          mMode = 1; loadCyc = n; mRem = TO;
        end
      endcase
    end
  endtask

  task automatic cyc(input logic rst);
    MainResetN = rst;
    tbIf.bCPUWrWdtRegSig = sig;
    @(posedge CLK32768);
    n++;
    modelStep(rst, sig);
    #1;
    chk("m_WdtRstN",  int'(tbIf.WdtRstN),      (mMode == 2) ? 0 : 1);
    chk("m_BiosSel",  int'(tbIf.BiosSel),      mBios);
    chk("m_WdtArmed", int'(tbIf.WdtArmed),     (mMode == 1) ? 1 : 0);
    chk("m_Remain",   int'(tbIf.WdtRemainSec), mRem);
    chk("m_ExpCnt",   int'(tbIf.WdtExpCnt),    mCnt);
  endtask

  task automatic doReset();
    cyc(1'b0);
    cyc(1'b0);
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] s;
    int eRstN, eBios, eArmed, eRem, eCnt;
  } vec_t;

  vec_t tv [18];
  int   lowCnt;

  initial begin
    tv = '{
      '{1'b0, 5'd0, 1, 0, 1, 3, 0}, '{1'b0, 5'd0, 1, 0, 1, 3, 0},
      '{1'b1, 5'd0, 1, 0, 1, 3, 0}, '{1'b1, 5'd0, 1, 0, 1, 3, 0},
      '{1'b1, 5'd0, 1, 0, 1, 3, 0}, '{1'b1, 5'd0, 1, 0, 1, 2, 0},
      '{1'b1, 5'd0, 1, 0, 1, 2, 0}, '{1'b1, 5'd0, 1, 0, 1, 2, 0},
      '{1'b1, 5'd0, 1, 0, 1, 2, 0}, '{1'b1, 5'd0, 1, 0, 1, 1, 0},
      '{1'b1, 5'd0, 1, 0, 1, 1, 0}, '{1'b1, 5'd0, 1, 0, 1, 1, 0},
      '{1'b1, 5'd0, 1, 0, 1, 1, 0}, '{1'b1, 5'd0, 0, 1, 0, 0, 1},
      '{1'b1, 5'd0, 0, 1, 0, 0, 1}, '{1'b1, 5'd0, 1, 1, 1, 3, 1},
      '{1'b1, 5'd0, 1, 1, 1, 3, 1}, '{1'b1, 5'd0, 1, 1, 1, 3, 1}
    };

    // Free-running countdown from reset through one expiry.
    for (int i = 0; i < 18; i++) begin
      sig = tv[i].s;
      cyc(tv[i].rst);
      chk("t_WdtRstN",  int'(tbIf.WdtRstN),      tv[i].eRstN);
      chk("t_BiosSel",  int'(tbIf.BiosSel),      tv[i].eBios);
      chk("t_WdtArmed", int'(tbIf.WdtArmed),     tv[i].eArmed);
      chk("t_Remain",   int'(tbIf.WdtRemainSec), tv[i].eRem);
      chk("t_ExpCnt",   int'(tbIf.WdtExpCnt),    tv[i].eCnt);
    end

    // Kick sampled at edge 6 reloads at edge 8; expiry moves to edge 20.
    doReset();
    for (int i = 1; i <= 20; i++) begin
      if (i == 6) sig[0] = ~sig[0];
      cyc(1'b1);
      if (i == 8)  chk("kick_reload", int'(tbIf.WdtRemainSec), 3);
      if (i == 19) chk("kick_pre_exp", int'(tbIf.WdtRstN), 1);
      if (i == 20) chk("kick_exp", int'(tbIf.WdtRstN), 0);
    end

    // Disable, quiet idle, then arm and time out 12 cycles after the load.
    doReset();
    sig[1] = ~sig[1];
    cyc(1'b1);
    cyc(1'b1); chk("dis_lat_arm", int'(tbIf.WdtArmed), 1);
    cyc(1'b1); chk("dis_armed", int'(tbIf.WdtArmed), 0);
    lowCnt = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1);
      if (tbIf.WdtRstN == 1'b0) lowCnt++;
    end
    chk("idle_no_rst", lowCnt, 0);
    sig[3] = ~sig[3];
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    chk("arm_armed", int'(tbIf.WdtArmed), 1);
    chk("arm_remain", int'(tbIf.WdtRemainSec), 3);
    for (int j = 1; j <= 12; j++) begin
      cyc(1'b1);
      if (j == 11) chk("arm_pre_exp", int'(tbIf.WdtRstN), 1);
      if (j == 12) chk("arm_exp", int'(tbIf.WdtRstN), 0);
    end

    // Kick and disable together: disable wins. Force in idle does nothing.
    doReset();
    sig = sig ^ 5'b00011;
    for (int i = 0; i < 3; i++) cyc(1'b1);
    chk("kd_idle", int'(tbIf.WdtArmed), 0);
    sig[2] = ~sig[2];
    for (int i = 0; i < 6; i++) cyc(1'b1);
    chk("force_idle_rst", int'(tbIf.WdtRstN), 1);
    chk("force_idle_arm", int'(tbIf.WdtArmed), 0);

    // Force while armed: two-cycle pulse two edges after the toggle.
    doReset();
    cyc(1'b1);
    sig[2] = ~sig[2];
    cyc(1'b1);
    cyc(1'b1); chk("frc_e3", int'(tbIf.WdtRstN), 1);
    cyc(1'b1); chk("frc_e4", int'(tbIf.WdtRstN), 0);
    cyc(1'b1); chk("frc_e5", int'(tbIf.WdtRstN), 0);
    cyc(1'b1); chk("frc_e6", int'(tbIf.WdtRstN), 1);
    for (int k = 2; k <= 5; k++) begin
      sig[2] = ~sig[2];
      for (int i = 0; i < 6; i++) cyc(1'b1);
      if (k == 4) begin
        chk("sat_cnt4", int'(tbIf.WdtExpCnt), 3);
        chk("sat_bios4", int'(tbIf.BiosSel), 0);
      end
      if (k == 5) begin
        chk("sat_cnt5", int'(tbIf.WdtExpCnt), 3);
        chk("sat_bios5", int'(tbIf.BiosSel), 1);
      end
    end
    // Reset in the middle of a pulse releases it and clears BiosSel.
    sig[2] = ~sig[2];
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    chk("mid_pulse_low", int'(tbIf.WdtRstN), 0);
    cyc(1'b0);
    chk("rst_pulse_end", int'(tbIf.WdtRstN), 1);
    chk("rst_bios", int'(tbIf.BiosSel), 0);
    cyc(1'b0);

    // Invalid code while armed.
    doReset();
    sig[4] = ~sig[4];
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    chk("other_armed", int'(tbIf.WdtRstN), (STRICT != 0) ? 0 : 1);
    for (int i = 0; i < 4; i++) cyc(1'b1);

    // Input changed and held across reset: no event after release.
    sig = 5'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1);
    sig = 5'b10101;
    doReset();
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1);
      if (i == 11) chk("hold_pre_exp", int'(tbIf.WdtRstN), 1);
      if (i == 12) chk("hold_exp", int'(tbIf.WdtRstN), 0);
    end

    // Random toggles and occasional resets against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) cyc(1'b0);
      else begin
        if ($urandom_range(0, 5) == 0) sig = sig ^ 5'($urandom_range(1, 31));
        cyc(1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
